math_adder_carry_pipelined: RTL and testbench
=============================================

// Module: math_adder_carry_pipelined
// PURPOSE
//  Parametrised pipelined add/subtract unit: N-bit operands split into CHUNK-bit
//  segments, one segment resolved per stage, inter-segment carry registered.
//  Successor to the single-cycle ripple adder for wide datapaths where a full
//  ripple misses timing. Valid/ready on both sides, full throughput, in-order.
// PARAMETERS
//  N      16  operand/sum width (N >= 1)
//  CHUNK  4   bits resolved per stage (1 <= CHUNK <= N); STAGES = ceil(N/CHUNK)
// PORTS
//  i_clk       in   1  clock, all state on rising edge
//  i_rst_n     in   1  asynchronous active-low reset
//  i_valid     in   1  upstream operand valid
//  o_ready     out  1  upstream may transfer (combinational from stage-0 state + i_ready)
//  i_a         in   N  operand A
//  i_b         in   N  operand B
//  i_c         in   1  carry-in (add mode only; ignored when i_sub=1)
//  i_sub       in   1  0: A+B+i_c ; 1: A-B (A + ~B + 1)
//  o_valid     out  1  result valid (registered)
//  i_ready     in   1  downstream accepts result
//  o_sum       out  N  result (registered)
//  o_carry     out  1  carry out of bit N-1 (sub mode: 1 = no borrow)
//  o_overflow  out  1  signed overflow = carry into bit N-1 XOR carry out of bit N-1
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert by system): all stage valids 0,
//    o_valid=0, o_sum=0, o_carry=0, o_overflow=0. Data regs may also clear to 0.
//  - Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
//  - Stage k (0..STAGES-1) resolves bits [k*CHUNK +: CHUNK]; last chunk is
//    N-(STAGES-1)*CHUNK bits wide when N % CHUNK != 0.
//  - Stage 0 entry: effective B = i_sub ? ~i_b : i_b; cin = i_sub ? 1 : i_c.
//  - Each stage register holds: valid, resolved low sum bits, pending high A/B
//    bits (skew), carry into next chunk. Stage k+1 uses registered carry of k.
//  - Last stage also captures carry-into-MSB to form o_overflow.
//  - Latency: STAGES cycles from input transfer to o_valid, no stalls.
//    STAGES=1 degenerates to a single registered adder (latency 1).
//  - Throughput: one transfer/cycle when i_ready held high.
//  - Per-stage advance: stage k loads when !v[k] || advance[k+1]; last stage
//    loads when !o_valid || i_ready. Bubbles collapse; o_ready = advance[0].
//  - Stall: while o_valid && !i_ready, o_sum/o_carry/o_overflow/o_valid hold.
//    Pipeline fills to STAGES entries then o_ready drops; no loss, no dup.
//  - Simultaneous in and out transfer when full: both occur, occupancy constant.
//  - Stage data regs load only on advance; invalid stages' data is don't-care
//    but must never reach outputs with o_valid=1.
//  - Reset mid-operation: all in-flight results dropped; first o_valid after
//    release only for operands transferred after release.
//  - Arithmetic modulo 2^N; no X-propagation from don't-care stages to outputs.
// TESTING
//  1. N=16,CHUNK=4: add 0xFFFF+0x0001,c=0 -> after 4 cycles sum=0x0000,carry=1,ovf=0.
//  2. sub 0x8000-0x0001 -> sum=0x7FFF,carry=1,ovf=1; sub 0x0000-0x0001 ->
//     sum=0xFFFF,carry=0,ovf=0.
//  3. 200 back-to-back random add/sub ops, i_ready=1 -> o_valid every cycle after
//     4-cycle fill, results in order match A+B+c / A-B scoreboard incl carry/ovf.
//  4. Random i_valid/i_ready toggling (50%) -> outputs stable during stall,
//     o_ready low only when 4 entries held and i_ready=0, no loss/dup.
//  5. Ragged N=10,CHUNK=4: 0x3FF+0x001 -> sum=0x000,carry=1 after 3 cycles;
//     N=8,CHUNK=8: 0x7F+0x01 -> sum=0x80,ovf=1 after 1 cycle.
//  6. Three ops in flight, pulse i_rst_n low mid-cycle -> o_valid=0 immediately
//     (async), outputs 0; after release no stale results emitted.

Source files
------------

// File: rtl/math_adder_carry_pipelined_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// master = upstream producer and downstream consumer side; slave = the adder.
interface math_adder_carry_pipelined_if #(
  parameter int N = 16
) ();
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         i_c;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_sum;
  logic         o_carry;
  logic         o_overflow;

  modport master (
    output i_valid, i_a, i_b, i_c, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow
  );

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow
  );
endinterface

// File: rtl/math_adder_carry_pipelined.sv
// Pipelined N-bit add/subtract: one CHUNK-bit segment resolved per stage, with the
// inter-segment carry registered so no ripple path spans more than one chunk.
module math_adder_carry_pipelined #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  math_adder_carry_pipelined_if.slave   bus
);
  localparam int STAGES = (N + CHUNK - 1) / CHUNK;

  logic         r_v   [STAGES];
  logic [N-1:0] r_a   [STAGES];
  logic [N-1:0] r_b   [STAGES];
  logic [N-1:0] r_s   [STAGES];
  logic         r_cy  [STAGES];
  logic         r_ovf;

  logic         w_adv  [STAGES+1];
  logic         w_in_v [STAGES];
  logic [N-1:0] w_in_a [STAGES];
  logic [N-1:0] w_in_b [STAGES];
  logic [N-1:0] w_in_s [STAGES];
  logic         w_in_c [STAGES];

  assign w_adv[STAGES] = bus.i_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * CHUNK;
      localparam int W  = (gi == STAGES - 1) ? (N - LO) : CHUNK;

      logic [W:0]   w_res;
      logic [N-1:0] w_s;

      // A stage may load when empty or when its content moves on this cycle.
      assign w_adv[gi] = !r_v[gi] || w_adv[gi+1];

      if (gi == 0) begin : g_entry
        assign w_in_v[gi] = bus.i_valid;
        assign w_in_a[gi] = bus.i_a;
        assign w_in_b[gi] = bus.i_sub ? ~bus.i_b : bus.i_b;
        assign w_in_s[gi] = '0;
        assign w_in_c[gi] = bus.i_sub | bus.i_c;
      end else begin : g_link
        assign w_in_v[gi] = r_v[gi-1];
        assign w_in_a[gi] = r_a[gi-1];
        assign w_in_b[gi] = r_b[gi-1];
        assign w_in_s[gi] = r_s[gi-1];
        assign w_in_c[gi] = r_cy[gi-1];
      end

      assign w_res = {1'b0, w_in_a[gi][LO +: W]} + {1'b0, w_in_b[gi][LO +: W]}
                   + {{W{1'b0}}, w_in_c[gi]};

      always_comb begin
        w_s           = w_in_s[gi];
        w_s[LO +: W]  = w_res[W-1:0];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_v[gi]  <= 1'b0;
          r_a[gi]  <= '0;
          r_b[gi]  <= '0;
          r_s[gi]  <= '0;
          r_cy[gi] <= 1'b0;
        end else if (w_adv[gi]) begin
          r_v[gi] <= w_in_v[gi];
          if (w_in_v[gi]) begin
            r_a[gi]  <= w_in_a[gi];
            r_b[gi]  <= w_in_b[gi];
            r_s[gi]  <= w_s;
            r_cy[gi] <= w_res[W];
          end
        end
      end

      if (gi == STAGES - 1) begin : g_last
        // Carry into the MSB is recovered from its sum bit and operand bits.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_adv[gi] && w_in_v[gi]) begin
            r_ovf <= w_res[W] ^ (w_res[W-1] ^ w_in_a[gi][N-1] ^ w_in_b[gi][N-1]);
          end
        end
      end
    end
  endgenerate

  assign bus.o_ready    = w_adv[0];
  assign bus.o_valid    = r_v[STAGES-1];
  assign bus.o_sum      = r_s[STAGES-1];
  assign bus.o_carry    = r_cy[STAGES-1];
  assign bus.o_overflow = r_ovf;
endmodule

// File: tb/tb_math_adder_carry_pipelined.sv
// Scoreboard bench for the pipelined adder: directed corner cases, back-to-back
// traffic, random valid/ready stalls, ragged chunking and asynchronous reset.
module tb_math_adder_carry_pipelined;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  math_adder_carry_pipelined_if #(.N(16)) bus16 ();
  math_adder_carry_pipelined_if #(.N(10)) bus10 ();
  math_adder_carry_pipelined_if #(.N(8))  bus8  ();

  math_adder_carry_pipelined #(.N(16), .CHUNK(4)) u_dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));
  math_adder_carry_pipelined #(.N(10), .CHUNK(4)) u_dut10 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus10));
  math_adder_carry_pipelined #(.N(8),  .CHUNK(8)) u_dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] sb [$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry, sum} for the 16-bit unit.
  function automatic logic [17:0] exp16(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : c)};
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    return {ovf, full[16], full[15:0]};
  endfunction

  // Called at posedge+1; drives one cycle of stimulus and scores it at posedge+2.
  task automatic step16(input logic v, input logic r, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic sub);
    logic [17:0] got;
    logic [17:0] e;
    bus16.i_valid = v;
    bus16.i_ready = r;
    bus16.i_a     = a;
    bus16.i_b     = b;
    bus16.i_c     = c;
    bus16.i_sub   = sub;
    #1;
    got = {bus16.o_overflow, bus16.o_carry, bus16.o_sum};
    if (prev_stall) begin
      check("stall_valid", bus16.o_valid, 1);
      check("stall_hold", got, prev_out);
    end
    check("o_ready", bus16.o_ready, !(sb.size() == 4 && !r));
    if (bus16.o_valid && r) begin
      check("out_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", got, e);
      end
    end
    if (v && bus16.o_ready) sb.push_back(exp16(a, b, c, sub));
    prev_stall = bus16.o_valid && !r;
    prev_out   = got;
    @(posedge clk);
    #1;
  endtask

  task automatic drain16();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      step16(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) step16(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic dir16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic sub, input logic [17:0] exp);
    int lat;
    bus16.i_a = a; bus16.i_b = b; bus16.i_c = c; bus16.i_sub = sub;
    bus16.i_valid = 1'b1; bus16.i_ready = 1'b1;
    #1;
    check({tag, "_ready"}, bus16.o_ready, 1);
    @(posedge clk); #1;
    bus16.i_valid = 1'b0;
    lat = 1;
    while (!bus16.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_out"}, {bus16.o_overflow, bus16.o_carry, bus16.o_sum}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    bus16.i_valid = 0; bus16.i_ready = 1; bus16.i_a = 0; bus16.i_b = 0; bus16.i_c = 0; bus16.i_sub = 0;
    bus10.i_valid = 0; bus10.i_ready = 1; bus10.i_a = 0; bus10.i_b = 0; bus10.i_c = 0; bus10.i_sub = 0;
    bus8.i_valid  = 0; bus8.i_ready  = 1; bus8.i_a  = 0; bus8.i_b  = 0; bus8.i_c  = 0; bus8.i_sub  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus16.o_valid, 0);
    check("rst_out", {bus16.o_overflow, bus16.o_carry, bus16.o_sum}, 0);
    check("rst_valid10", bus10.o_valid, 0);
    check("rst_valid8", bus8.o_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    dir16("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    dir16("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    dir16("sub_0_1",    16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
    dir16("add_cin",    16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h8000});

    bus10.i_a = 10'h3FF; bus10.i_b = 10'h001; bus10.i_valid = 1'b1;
    @(posedge clk); #1;
    bus10.i_valid = 1'b0;
    lat = 1;
    while (!bus10.o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("n10_lat", lat, 3);
    check("n10_out", {bus10.o_overflow, bus10.o_carry, bus10.o_sum}, {1'b0, 1'b1, 10'h000});

    bus8.i_a = 8'h7F; bus8.i_b = 8'h01; bus8.i_valid = 1'b1;
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    lat = 1;
    while (!bus8.o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("n8_lat", lat, 1);
    check("n8_out", {bus8.o_overflow, bus8.o_carry, bus8.o_sum}, {1'b1, 1'b0, 8'h80});
    @(posedge clk); #1;

    prev_stall = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i >= 4) check("b2b_valid", bus16.o_valid, 1);
      step16(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
    drain16();

    for (int i = 0; i < 400; i++) begin
      step16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
             16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain16();

    repeat (3) step16(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    bus16.i_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus16.o_valid, 0);
    check("async_rst_out", {bus16.o_overflow, bus16.o_carry, bus16.o_sum}, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_idle", bus16.o_valid, 0);
      step16(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    step16(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
    drain16();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
